id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register, directly downstream of the ID-stage control decoder and register file.
- Captures the decoded control bundle, operands, immediate, PC values, register indices and funct3 at the end of ID, and presents them to EX.
- Supports hazard-unit stall (hold) and flush (bubble insertion), plus a valid bit so EX and later stages can distinguish real instructions from bubbles.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_ADDR_W, 5, register index width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- StallE_i  in  1  hold all EX-side outputs this cycle.
- FlushE_i  in  1  replace the captured instruction with a bubble.
- ValidD_i  in  1  ID holds a real instruction.
- RegWriteD_i / MemWriteD_i / JumpD_i / BranchD_i / ALUSrcD_i / Is_U_typeD_i / ALUModifierD_i / mem_2_storeD_i  in  1 each  decoded controls.
- ResultSrcD_i  in  2  writeback select.
- ALUControlD_i  in  3  ALU operation.
- funct3D_i  in  3  branch/load/store sub-type.
- RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i  in  XLEN each  operands, immediate, PC values.
- Rs1D_i, Rs2D_i, RdD_i  in  REG_ADDR_W each  register indices.
- Outputs: one E-suffixed, _o-suffixed registered copy of every D input above, including ValidE_o. Same widths.
- BubbleCnt_o  out  32  present only with the optional feature.

Behaviour:
- Reset (rst_ni low, asynchronous): every output is 0, including ValidE_o and every control bit. Release takes effect at the first rising edge after deassertion.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority: reset > FlushE_i > StallE_i > load.
  - Load: all fields take their D inputs.
  - Stall: all fields hold their previous value; ValidE_o is also held.
  - Flush: ValidE_o=0; RegWrite, MemWrite, Jump, Branch, mem_2_store are cleared; all remaining control and data fields are cleared to 0. The bubble is architecturally a NOP with no side effects.
- Flush and stall asserted together: flush wins and a bubble is loaded.
- Load with ValidD_i=0: the fields are loaded as-is. The side-effect bits (RegWrite, MemWrite, Jump, Branch, mem_2_store) are gated to 0 at capture, so an invalid ID slot can never write or redirect.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: outputs clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - BubbleCnt_o exists.
  - 32-bit counter, reset to 0; increments by 1 on each edge where a bubble is loaded (flush, or load with ValidD_i=0). Stall edges do not increment it.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef id_ex_ctrl_t: packed struct of all control fields.
  - typedef id_ex_data_t: operands, PCs, immediate, indices, funct3.
  - XLEN and REG_ADDR_W constants.
  - Constant ID_EX_CTRL_NOP: the all-zero control struct.
- Sub-module pipe_reg_en_clr: generic WIDTH-parameterised register with asynchronous active-low reset, enable and synchronous clear. Instantiated once for the control struct and once for the data struct. The side-effect gating stays in id_ex_pipe_reg.

Test Plan:
- Reset: drive all inputs to 1s, pulse rst_ni low mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- Load: RegWriteD=1, ALUControlD=3'b010, RD1D=0x12345678, RdD=5, ValidD=1 -> identical values on outputs one edge later, ValidE_o=1.
- Stall: load instruction A, then assert StallE for 3 edges while inputs change to B -> outputs remain A for all 3 edges; B appears one edge after StallE drops.
- Flush with stall: FlushE=1 and StallE=1 with MemWriteD=1, ValidD=1 -> next edge MemWriteE_o=0, ValidE_o=0, all data fields 0.
- Invalid slot: ValidD=0, RegWriteD=1, JumpD=1, RD2D=0xAA -> RegWriteE_o=0, JumpE_o=0, RD2E_o=0xAA, ValidE_o=0.
- With ID_EX_BUBBLE_CNT_EN: 2 flushes, 1 invalid load and 4 stall edges -> BubbleCnt_o=3. Force the counter to 0xFFFFFFFF, then one flush -> BubbleCnt_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline types: ID/EX control and data bundles, datapath widths.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic       is_u_type;
      logic       alu_modifier;
      logic       mem_2_store;
      logic [1:0] result_src;
      logic [2:0] alu_control;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0]       rd1;
      logic [XLEN-1:0]       rd2;
      logic [XLEN-1:0]       imm_ext;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       pc_plus4;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [2:0]            funct3;
   } id_ex_data_t;

   localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_reg_if.sv
//------------------------------------------------------------------------------
// id_ex_pipe_reg_if
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface id_ex_pipe_reg_if;
   import pipe_pkg::*;

   logic                  StallE_i, FlushE_i, ValidD_i;
   logic                  RegWriteD_i, MemWriteD_i, JumpD_i, BranchD_i;
   logic                  ALUSrcD_i, Is_U_typeD_i, ALUModifierD_i, mem_2_storeD_i;
   logic [1:0]            ResultSrcD_i;
   logic [2:0]            ALUControlD_i, funct3D_i;
   logic [XLEN-1:0]       RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i;
   logic [REG_ADDR_W-1:0] Rs1D_i, Rs2D_i, RdD_i;

   logic                  ValidE_o;
   logic                  RegWriteE_o, MemWriteE_o, JumpE_o, BranchE_o;
   logic                  ALUSrcE_o, Is_U_typeE_o, ALUModifierE_o, mem_2_storeE_o;
   logic [1:0]            ResultSrcE_o;
   logic [2:0]            ALUControlE_o, funct3E_o;
   logic [XLEN-1:0]       RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o;
   logic [REG_ADDR_W-1:0] Rs1E_o, Rs2E_o, RdE_o;

   modport master (
      output StallE_i, FlushE_i, ValidD_i,
             RegWriteD_i, MemWriteD_i, JumpD_i, BranchD_i,
             ALUSrcD_i, Is_U_typeD_i, ALUModifierD_i, mem_2_storeD_i,
             ResultSrcD_i, ALUControlD_i, funct3D_i,
             RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i,
             Rs1D_i, Rs2D_i, RdD_i,
      input  ValidE_o,
             RegWriteE_o, MemWriteE_o, JumpE_o, BranchE_o,
             ALUSrcE_o, Is_U_typeE_o, ALUModifierE_o, mem_2_storeE_o,
             ResultSrcE_o, ALUControlE_o, funct3E_o,
             RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o,
             Rs1E_o, Rs2E_o, RdE_o
   );

   modport slave (
      input  StallE_i, FlushE_i, ValidD_i,
             RegWriteD_i, MemWriteD_i, JumpD_i, BranchD_i,
             ALUSrcD_i, Is_U_typeD_i, ALUModifierD_i, mem_2_storeD_i,
             ResultSrcD_i, ALUControlD_i, funct3D_i,
             RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i,
             Rs1D_i, Rs2D_i, RdD_i,
      output ValidE_o,
             RegWriteE_o, MemWriteE_o, JumpE_o, BranchE_o,
             ALUSrcE_o, Is_U_typeE_o, ALUModifierE_o, mem_2_storeE_o,
             ResultSrcE_o, ALUControlE_o, funct3E_o,
             RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o,
             Rs1E_o, Rs2E_o, RdE_o
   );

endinterface

`default_nettype wire

// File: rtl/pipe_reg_en_clr.sv
//------------------------------------------------------------------------------
// pipe_reg_en_clr
// Generic register: async active-low reset, synchronous clear over enable.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_en_clr #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register with stall, flush and valid tracking.
// Optional bubble counter enabled by macro ID_EX_BUBBLE_CNT_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_pipe_reg
   import pipe_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]     BubbleCnt_o
`endif
);

   id_ex_ctrl_t ctrl_d, ctrl_q;
   id_ex_data_t data_d, data_q;
   logic        load_en;

   assign load_en = ~bus.StallE_i;

   // Side-effect bits are gated by ValidD so an empty ID slot can never write or redirect.
   always_comb begin
      ctrl_d              = ID_EX_CTRL_NOP;
      ctrl_d.valid        = bus.ValidD_i;
      ctrl_d.reg_write    = bus.RegWriteD_i    & bus.ValidD_i;
      ctrl_d.mem_write    = bus.MemWriteD_i    & bus.ValidD_i;
      ctrl_d.jump         = bus.JumpD_i        & bus.ValidD_i;
      ctrl_d.branch       = bus.BranchD_i      & bus.ValidD_i;
      ctrl_d.mem_2_store  = bus.mem_2_storeD_i & bus.ValidD_i;
      ctrl_d.alu_src      = bus.ALUSrcD_i;
      ctrl_d.is_u_type    = bus.Is_U_typeD_i;
      ctrl_d.alu_modifier = bus.ALUModifierD_i;
      ctrl_d.result_src   = bus.ResultSrcD_i;
      ctrl_d.alu_control  = bus.ALUControlD_i;
   end

   always_comb begin
      data_d          = '0;
      data_d.rd1      = bus.RD1D_i;
      data_d.rd2      = bus.RD2D_i;
      data_d.imm_ext  = bus.ImmExtD_i;
      data_d.pc       = bus.PCD_i;
      data_d.pc_plus4 = bus.PCPlus4D_i;
      data_d.rs1      = bus.Rs1D_i;
      data_d.rs2      = bus.Rs2D_i;
      data_d.rd       = bus.RdD_i;
      data_d.funct3   = bus.funct3D_i;
   end

   pipe_reg_en_clr #(.WIDTH($bits(id_ex_ctrl_t))) u_ctrl_reg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en     (load_en),
      .clr    (bus.FlushE_i),
      .d      (ctrl_d),
      .q      (ctrl_q)
   );

   pipe_reg_en_clr #(.WIDTH($bits(id_ex_data_t))) u_data_reg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en     (load_en),
      .clr    (bus.FlushE_i),
      .d      (data_d),
      .q      (data_q)
   );

   assign bus.ValidE_o       = ctrl_q.valid;
   assign bus.RegWriteE_o    = ctrl_q.reg_write;
   assign bus.MemWriteE_o    = ctrl_q.mem_write;
   assign bus.JumpE_o        = ctrl_q.jump;
   assign bus.BranchE_o      = ctrl_q.branch;
   assign bus.ALUSrcE_o      = ctrl_q.alu_src;
   assign bus.Is_U_typeE_o   = ctrl_q.is_u_type;
   assign bus.ALUModifierE_o = ctrl_q.alu_modifier;
   assign bus.mem_2_storeE_o = ctrl_q.mem_2_store;
   assign bus.ResultSrcE_o   = ctrl_q.result_src;
   assign bus.ALUControlE_o  = ctrl_q.alu_control;
   assign bus.RD1E_o         = data_q.rd1;
   assign bus.RD2E_o         = data_q.rd2;
   assign bus.ImmExtE_o      = data_q.imm_ext;
   assign bus.PCE_o          = data_q.pc;
   assign bus.PCPlus4E_o     = data_q.pc_plus4;
   assign bus.Rs1E_o         = data_q.rs1;
   assign bus.Rs2E_o         = data_q.rs2;
   assign bus.RdE_o          = data_q.rd;
   assign bus.funct3E_o      = data_q.funct3;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
   logic        bubble_load;

   // A bubble enters EX on a flush, or on a non-stalled load of an empty ID slot.
   assign bubble_load = bus.FlushE_i | (~bus.StallE_i & ~bus.ValidD_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bubble_cnt <= '0;
      end else if (bubble_load) begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end

   assign BubbleCnt_o = bubble_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Scoreboard bench for the ID/EX pipeline register (directed + random).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_pipe_reg;
   import pipe_pkg::*;

   typedef struct packed {
      logic        valid, reg_write, mem_write, jump, branch;
      logic        alu_src, is_u_type, alu_modifier, mem_2_store;
      logic [1:0]  result_src;
      logic [2:0]  alu_control, funct3;
      logic [31:0] rd1, rd2, imm_ext, pc, pc_plus4;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] cnt;
   } snap_t;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   id_ex_pipe_reg_if bus();
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] BubbleCnt_o;
`endif

   id_ex_pipe_reg dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .BubbleCnt_o (BubbleCnt_o)
`endif
   );

   int    vectors     = 0;
   int    miscompares = 0;
   snap_t exp_q[$];
   string name_q[$];
   snap_t model_q;
   logic [31:0] model_cnt;

   function automatic snap_t d_side();
      snap_t s = '0;
      s.valid = bus.ValidD_i;         s.reg_write = bus.RegWriteD_i;
      s.mem_write = bus.MemWriteD_i;  s.jump = bus.JumpD_i;
      s.branch = bus.BranchD_i;       s.alu_src = bus.ALUSrcD_i;
      s.is_u_type = bus.Is_U_typeD_i; s.alu_modifier = bus.ALUModifierD_i;
      s.mem_2_store = bus.mem_2_storeD_i;
      s.result_src = bus.ResultSrcD_i; s.alu_control = bus.ALUControlD_i;
      s.funct3 = bus.funct3D_i;
      s.rd1 = bus.RD1D_i; s.rd2 = bus.RD2D_i; s.imm_ext = bus.ImmExtD_i;
      s.pc = bus.PCD_i;   s.pc_plus4 = bus.PCPlus4D_i;
      s.rs1 = bus.Rs1D_i; s.rs2 = bus.Rs2D_i; s.rd = bus.RdD_i;
      return s;
   endfunction

   function automatic snap_t e_side();
      snap_t s = '0;
      s.valid = bus.ValidE_o;         s.reg_write = bus.RegWriteE_o;
      s.mem_write = bus.MemWriteE_o;  s.jump = bus.JumpE_o;
      s.branch = bus.BranchE_o;       s.alu_src = bus.ALUSrcE_o;
      s.is_u_type = bus.Is_U_typeE_o; s.alu_modifier = bus.ALUModifierE_o;
      s.mem_2_store = bus.mem_2_storeE_o;
      s.result_src = bus.ResultSrcE_o; s.alu_control = bus.ALUControlE_o;
      s.funct3 = bus.funct3E_o;
      s.rd1 = bus.RD1E_o; s.rd2 = bus.RD2E_o; s.imm_ext = bus.ImmExtE_o;
      s.pc = bus.PCE_o;   s.pc_plus4 = bus.PCPlus4E_o;
      s.rs1 = bus.Rs1E_o; s.rs2 = bus.Rs2E_o; s.rd = bus.RdE_o;
`ifdef ID_EX_BUBBLE_CNT_EN
      s.cnt = BubbleCnt_o;
`endif
      return s;
   endfunction

   task automatic set_all(input logic v);
      bus.ValidD_i = v; bus.RegWriteD_i = v; bus.MemWriteD_i = v; bus.JumpD_i = v;
      bus.BranchD_i = v; bus.ALUSrcD_i = v; bus.Is_U_typeD_i = v;
      bus.ALUModifierD_i = v; bus.mem_2_storeD_i = v;
      bus.ResultSrcD_i = {2{v}}; bus.ALUControlD_i = {3{v}}; bus.funct3D_i = {3{v}};
      bus.RD1D_i = {32{v}}; bus.RD2D_i = {32{v}}; bus.ImmExtD_i = {32{v}};
      bus.PCD_i = {32{v}};  bus.PCPlus4D_i = {32{v}};
      bus.Rs1D_i = {5{v}};  bus.Rs2D_i = {5{v}};  bus.RdD_i = {5{v}};
   endtask

   task automatic set_rand();
      bus.ValidD_i = 1'($urandom); bus.RegWriteD_i = 1'($urandom);
      bus.MemWriteD_i = 1'($urandom); bus.JumpD_i = 1'($urandom);
      bus.BranchD_i = 1'($urandom); bus.ALUSrcD_i = 1'($urandom);
      bus.Is_U_typeD_i = 1'($urandom); bus.ALUModifierD_i = 1'($urandom);
      bus.mem_2_storeD_i = 1'($urandom);
      bus.ResultSrcD_i = 2'($urandom); bus.ALUControlD_i = 3'($urandom);
      bus.funct3D_i = 3'($urandom);
      bus.RD1D_i = $urandom; bus.RD2D_i = $urandom; bus.ImmExtD_i = $urandom;
      bus.PCD_i = $urandom;  bus.PCPlus4D_i = $urandom;
      bus.Rs1D_i = 5'($urandom); bus.Rs2D_i = 5'($urandom); bus.RdD_i = 5'($urandom);
   endtask

   // Called just after a falling edge with inputs settled; predicts the state after the next rising edge.
   task automatic issue(input string name);
      snap_t n;
      logic  bubble;
      if (bus.FlushE_i) begin
         n = '0;
         bubble = 1'b1;
      end else if (bus.StallE_i) begin
         n = model_q;
         bubble = 1'b0;
      end else begin
         n = d_side();
         bubble = !n.valid;
         if (!n.valid) begin
            n.reg_write = 1'b0; n.mem_write = 1'b0; n.jump = 1'b0;
            n.branch = 1'b0;    n.mem_2_store = 1'b0;
         end
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      if (bubble) model_cnt = model_cnt + 32'd1;
      n.cnt = model_cnt;
`else
      n.cnt = '0;
`endif
      model_q = n;
      exp_q.push_back(n);
      name_q.push_back(name);
      @(negedge clk_i);
   endtask

   // Asynchronous reset in the middle of a low phase; outputs must clear before any clock edge.
   task automatic pulse_reset(input string name);
      snap_t a;
      #2 rst_ni = 1'b0;
      #1 a = e_side();
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL %s: got %h expected all zero", name, a);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_q = '0;
      model_cnt = '0;
   endtask

   always @(posedge clk_i) begin
      snap_t e, a;
      string nm;
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = e_side();
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      bus.StallE_i = 1'b0;
      bus.FlushE_i = 1'b0;
      set_all(1'b0);
      model_q = '0;
      model_cnt = '0;
      @(negedge clk_i);
      pulse_reset("reset_initial");

      // Reset with every input high, after a full-ones load
      set_all(1'b1);
      issue("load_all_ones");
      pulse_reset("reset_async_all_ones");

      set_all(1'b0);
      bus.RegWriteD_i = 1'b1; bus.ALUControlD_i = 3'b010;
      bus.RD1D_i = 32'h1234_5678; bus.RdD_i = 5'd5; bus.ValidD_i = 1'b1;
      issue("load_basic");

      set_rand(); bus.ValidD_i = 1'b1;
      issue("stall_load_A");
      set_rand(); bus.ValidD_i = 1'b1; bus.StallE_i = 1'b1;
      repeat (3) issue("stall_hold_A");
      bus.StallE_i = 1'b0;
      issue("stall_release_B");

      set_rand(); bus.MemWriteD_i = 1'b1; bus.ValidD_i = 1'b1;
      bus.FlushE_i = 1'b1; bus.StallE_i = 1'b1;
      issue("flush_with_stall");
      bus.FlushE_i = 1'b0; bus.StallE_i = 1'b0;

      set_all(1'b0);
      bus.RegWriteD_i = 1'b1; bus.JumpD_i = 1'b1; bus.RD2D_i = 32'hAA;
      issue("invalid_slot");

      // Stall during reset assertion
      set_rand(); bus.StallE_i = 1'b1;
      issue("stall_before_reset");
      pulse_reset("reset_mid_stall");
      bus.StallE_i = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
      set_rand(); bus.ValidD_i = 1'b1; bus.FlushE_i = 1'b1;
      repeat (2) issue("cnt_flush");
      bus.FlushE_i = 1'b0; bus.ValidD_i = 1'b0;
      issue("cnt_invalid");
      bus.StallE_i = 1'b1;
      repeat (4) issue("cnt_stall");
      bus.StallE_i = 1'b0;
      vectors++;
      if (BubbleCnt_o !== 32'd3) begin
         miscompares++;
         $display("FAIL cnt_three: got %0d expected 3", BubbleCnt_o);
      end
      force dut.bubble_cnt = 32'hFFFF_FFFF;
      #1 release dut.bubble_cnt;
      model_cnt = 32'hFFFF_FFFF;
      bus.FlushE_i = 1'b1;
      issue("cnt_wrap");
      bus.FlushE_i = 1'b0;
`endif

      for (int i = 0; i < 400; i++) begin
         set_rand();
         bus.FlushE_i = ($urandom_range(0, 7) == 0);
         bus.StallE_i = ($urandom_range(0, 3) == 0);
         issue("random");
      end
      bus.FlushE_i = 1'b0;
      bus.StallE_i = 1'b0;

      repeat (3) @(negedge clk_i);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
